// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with same-cycle writeback bypass, load-use hazard
// detection, bubble insertion and a hazard-bubble counter.
`timescale 1ns/1ps
module id_ex_stage #(
  parameter int XLEN   = 32,
  parameter int CTRL_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              id_valid,
  input  logic [XLEN-1:0]   id_pc,
  input  logic [4:0]        rs1,
  input  logic [4:0]        rs2,
  input  logic [4:0]        rd,
  input  logic [XLEN-1:0]   dataA,
  input  logic [XLEN-1:0]   dataB,
  input  logic [XLEN-1:0]   id_imm,
  input  logic [CTRL_W-1:0] id_ctrl,
  input  logic              id_mem_read,
  input  logic              id_reg_wen,
  input  logic [4:0]        wb_rd,
  input  logic [XLEN-1:0]   wb,
  input  logic              RegWen,
  input  logic              flush,
  input  logic              ex_stall,
  output logic              stall,
  output logic              ex_valid,
  output logic              ex_mem_read,
  output logic              ex_reg_wen,
  output logic [XLEN-1:0]   ex_pc,
  output logic [XLEN-1:0]   ex_dataA,
  output logic [XLEN-1:0]   ex_dataB,
  output logic [XLEN-1:0]   ex_imm,
  output logic [4:0]        ex_rs1,
  output logic [4:0]        ex_rs2,
  output logic [4:0]        ex_rd,
  output logic [CTRL_W-1:0] ex_ctrl,
  output logic [CNT_W-1:0]  hz_count
);

  logic [XLEN-1:0] op_a;
  logic [XLEN-1:0] op_b;
  logic            hazard;

  // Writeback lands in the register file at the same edge the operands are
  // captured, so the read data is stale by one write; patch it here.
  always_comb begin
    op_a = dataA;
    op_b = dataB;
    if (RegWen && (wb_rd != 5'd0) && (wb_rd == rs1)) op_a = wb;
    if (RegWen && (wb_rd != 5'd0) && (wb_rd == rs2)) op_b = wb;
  end

  // rs2 is compared even for instructions that do not read it.
  assign hazard = id_valid && ex_valid && ex_mem_read && (ex_rd != 5'd0) &&
                  ((ex_rd == rs1) || (ex_rd == rs2));

  // Handshake: stall=1 asks upstream to hold PC and IF/ID this cycle; ex_stall=1
  // from downstream holds this register; flush and reset override both.
  assign stall = rst_n && !flush && (ex_stall || hazard);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ex_valid    <= 1'b0;
      ex_mem_read <= 1'b0;
      ex_reg_wen  <= 1'b0;
      ex_pc       <= '0;
      ex_dataA    <= '0;
      ex_dataB    <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= '0;
      hz_count    <= '0;
    end else if (flush || (!ex_stall && hazard)) begin
      ex_valid    <= 1'b0;
      ex_mem_read <= 1'b0;
      ex_reg_wen  <= 1'b0;
      ex_pc       <= '0;
      ex_dataA    <= '0;
      ex_dataB    <= '0;
      ex_imm      <= '0;
      ex_rs1      <= '0;
      ex_rs2      <= '0;
      ex_rd       <= '0;
      ex_ctrl     <= '0;
      if (!flush) hz_count <= hz_count + 1'b1;
    end else if (!ex_stall) begin
      ex_valid    <= id_valid;
      ex_mem_read <= id_valid && id_mem_read;
      ex_reg_wen  <= id_valid && id_reg_wen;
      ex_pc       <= id_pc;
      ex_dataA    <= op_a;
      ex_dataB    <= op_b;
      ex_imm      <= id_imm;
      ex_rs1      <= rs1;
      ex_rs2      <= rs2;
      ex_rd       <= rd;
      ex_ctrl     <= id_ctrl;
    end
  end

endmodule

// File: tb/tb_id_ex_stage.sv
// Bench for id_ex_stage: directed test-plan checks plus randomized traffic
// compared every cycle against a behavioural model of the stage.
`timescale 1ns/1ps
module tb_id_ex_stage;

  localparam int XLEN   = 32;
  localparam int CTRL_W = 8;
  localparam int CNT_W  = 4;   // small so the counter wraps during random traffic

  logic              clk = 1'b0;
  logic              rst_n, id_valid, id_mem_read, id_reg_wen, RegWen, flush, ex_stall;
  logic [XLEN-1:0]   id_pc, dataA, dataB, id_imm, wb;
  logic [4:0]        rs1, rs2, rd, wb_rd;
  logic [CTRL_W-1:0] id_ctrl;
  logic              stall, ex_valid, ex_mem_read, ex_reg_wen;
  logic [XLEN-1:0]   ex_pc, ex_dataA, ex_dataB, ex_imm;
  logic [4:0]        ex_rs1, ex_rs2, ex_rd;
  logic [CTRL_W-1:0] ex_ctrl;
  logic [CNT_W-1:0]  hz_count;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(XLEN), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_pc(id_pc),
    .rs1(rs1), .rs2(rs2), .rd(rd), .dataA(dataA), .dataB(dataB),
    .id_imm(id_imm), .id_ctrl(id_ctrl), .id_mem_read(id_mem_read),
    .id_reg_wen(id_reg_wen), .wb_rd(wb_rd), .wb(wb), .RegWen(RegWen),
    .flush(flush), .ex_stall(ex_stall), .stall(stall), .ex_valid(ex_valid),
    .ex_mem_read(ex_mem_read), .ex_reg_wen(ex_reg_wen), .ex_pc(ex_pc),
    .ex_dataA(ex_dataA), .ex_dataB(ex_dataB), .ex_imm(ex_imm),
    .ex_rs1(ex_rs1), .ex_rs2(ex_rs2), .ex_rd(ex_rd), .ex_ctrl(ex_ctrl),
    .hz_count(hz_count)
  );

  // ---------------- behavioural model ----------------
  typedef struct packed {
    logic              valid;
    logic              mem_read;
    logic              reg_wen;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   a;
    logic [XLEN-1:0]   b;
    logic [XLEN-1:0]   imm;
    logic [4:0]        r1;
    logic [4:0]        r2;
    logic [4:0]        rdst;
    logic [CTRL_W-1:0] ctrl;
  } ex_slot_t;

  ex_slot_t         m = '0;
  logic [CNT_W-1:0] m_cnt = '0;

  function automatic logic [XLEN-1:0] read_reg(input logic [4:0] idx, input logic [XLEN-1:0] rf);
    if (RegWen && wb_rd != 0 && wb_rd == idx) return wb;
    return rf;
  endfunction

  function automatic bit load_use(input ex_slot_t s);
    return id_valid && s.valid && s.mem_read && s.rdst != 0 &&
           (s.rdst == rs1 || s.rdst == rs2);
  endfunction

  always @(posedge clk) begin
    ex_slot_t nx;
    nx = m;
    if (!rst_n) begin
      nx = '0;
      m_cnt <= '0;
    end else if (flush) begin
      nx = '0;
    end else if (ex_stall) begin
      nx = m;
    end else if (load_use(m)) begin
      nx = '0;
      m_cnt <= m_cnt + 1'b1;
    end else begin
      nx.valid    = id_valid;
      nx.mem_read = id_valid ? id_mem_read : 1'b0;
      nx.reg_wen  = id_valid ? id_reg_wen  : 1'b0;
      nx.pc       = id_pc;
      nx.a        = read_reg(rs1, dataA);
      nx.b        = read_reg(rs2, dataB);
      nx.imm      = id_imm;
      nx.r1       = rs1;
      nx.r2       = rs2;
      nx.rdst     = rd;
      nx.ctrl     = id_ctrl;
    end
    m <= nx;
  end

  // ---------------- scoreboard ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s @%0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (chk_en) begin
      chk("m_stall", stall, rst_n && !flush && (ex_stall || load_use(m)));
      chk("m_valid", ex_valid, m.valid);
      chk("m_mem_read", ex_mem_read, m.mem_read);
      chk("m_reg_wen", ex_reg_wen, m.reg_wen);
      chk("m_pc", ex_pc, m.pc);
      chk("m_dataA", ex_dataA, m.a);
      chk("m_dataB", ex_dataB, m.b);
      chk("m_imm", ex_imm, m.imm);
      chk("m_rs1", ex_rs1, m.r1);
      chk("m_rs2", ex_rs2, m.r2);
      chk("m_rd", ex_rd, m.rdst);
      chk("m_ctrl", ex_ctrl, m.ctrl);
      chk("m_hz_count", hz_count, m_cnt);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    rst_n = 1'b1; id_valid = 1'b0; id_pc = '0; rs1 = '0; rs2 = '0; rd = '0;
    dataA = '0; dataB = '0; id_imm = '0; id_ctrl = '0; id_mem_read = 1'b0;
    id_reg_wen = 1'b0; wb_rd = '0; wb = '0; RegWen = 1'b0; flush = 1'b0;
    ex_stall = 1'b0;
  endtask

  task automatic issue(input logic [4:0] s1, input logic [4:0] s2, input logic [4:0] d,
                       input logic [XLEN-1:0] a, input logic [XLEN-1:0] b, input logic ld);
    id_valid = 1'b1; rs1 = s1; rs2 = s2; rd = d; dataA = a; dataB = b;
    id_mem_read = ld; id_reg_wen = 1'b1; id_pc = id_pc + 4; id_ctrl = id_ctrl + 1;
  endtask

  task automatic rand_inputs();
    rst_n       = ($urandom_range(0, 99) != 0);
    flush       = ($urandom_range(0, 99) < 8);
    ex_stall    = ($urandom_range(0, 99) < 15);
    id_valid    = ($urandom_range(0, 99) < 80);
    id_pc       = $urandom;
    rs1         = 5'($urandom_range(0, 7));
    rs2         = 5'($urandom_range(0, 7));
    rd          = 5'($urandom_range(0, 7));
    dataA       = $urandom;
    dataB       = $urandom;
    id_imm      = $urandom;
    id_ctrl     = 8'($urandom);
    id_mem_read = ($urandom_range(0, 99) < 35);
    id_reg_wen  = 1'($urandom);
    wb_rd       = 5'($urandom_range(0, 7));
    wb          = $urandom;
    RegWen      = 1'($urandom);
  endtask

  // ---------------- directed + random stimulus ----------------
  initial begin
    quiet();
    // reset with downstream hold and a valid ID instruction
    rst_n = 1'b0; ex_stall = 1'b1; id_valid = 1'b1; rs1 = 5'd3; dataA = 32'h55;
    @(negedge clk); chk("rst_stall0", stall, 1'b0);
    tick();
    chk_en = 1'b1;
    chk("rst_valid", ex_valid, 1'b0);
    chk("rst_dataA", ex_dataA, 32'h0);
    chk("rst_rs1", ex_rs1, 5'd0);
    chk("rst_hz", hz_count, 4'd0);
    @(negedge clk); chk("rst_stall1", stall, 1'b0);
    tick();
    quiet();

    // plain issue
    issue(5'd3, 5'd4, 5'd5, 32'h11, 32'h22, 1'b0); id_imm = 32'h100;
    @(negedge clk); chk("plain_stall", stall, 1'b0);
    tick();
    chk("plain_dataA", ex_dataA, 32'h11);
    chk("plain_dataB", ex_dataB, 32'h22);
    chk("plain_rd", ex_rd, 5'd5);
    chk("plain_valid", ex_valid, 1'b1);
    chk("plain_imm", ex_imm, 32'h100);

    // writeback bypass, then index 0 never bypasses
    issue(5'd3, 5'd3, 5'd5, 32'h11, 32'h11, 1'b0);
    RegWen = 1'b1; wb_rd = 5'd3; wb = 32'hDEADBEEF;
    tick();
    chk("byp_dataA", ex_dataA, 32'hDEADBEEF);
    chk("byp_dataB", ex_dataB, 32'hDEADBEEF);
    wb_rd = 5'd0; rs1 = 5'd0; dataA = 32'h0;
    tick();
    chk("byp0_dataA", ex_dataA, 32'h0);
    chk("byp0_dataB", ex_dataB, 32'h11);
    RegWen = 1'b0;

    // load-use: one bubble, counted once
    issue(5'd1, 5'd2, 5'd7, 32'h1, 32'h2, 1'b1);
    tick();
    issue(5'd1, 5'd7, 5'd8, 32'h3, 32'h4, 1'b0);
    @(negedge clk); chk("lu_stall", stall, 1'b1);
    tick();
    chk("lu_bubble", ex_valid, 1'b0);
    chk("lu_hz", hz_count, 4'd1);
    @(negedge clk); chk("lu_release", stall, 1'b0);
    tick();
    chk("lu_rs2", ex_rs2, 5'd7);
    chk("lu_valid", ex_valid, 1'b1);

    // flush beats a load-use hazard and is not counted
    issue(5'd1, 5'd2, 5'd9, 32'h5, 32'h6, 1'b1);
    tick();
    issue(5'd9, 5'd2, 5'd10, 32'h7, 32'h8, 1'b0); flush = 1'b1;
    @(negedge clk); chk("fl_stall", stall, 1'b0);
    tick();
    chk("fl_valid", ex_valid, 1'b0);
    chk("fl_hz", hz_count, 4'd1);
    flush = 1'b0;

    // downstream hold for three cycles, then release loads the last ID values
    issue(5'd1, 5'd2, 5'd10, 32'hAA, 32'hBB, 1'b0);
    tick();
    ex_stall = 1'b1;
    for (int i = 0; i < 3; i++) begin
      issue(5'd4, 5'd5, 5'(11 + i), 32'h300 + i, 32'h400 + i, 1'b0);
      @(negedge clk); chk("hold_stall", stall, 1'b1);
      tick();
      chk("hold_dataA", ex_dataA, 32'hAA);
      chk("hold_rd", ex_rd, 5'd10);
      chk("hold_hz", hz_count, 4'd1);
    end
    ex_stall = 1'b0;
    tick();
    chk("rel_dataA", ex_dataA, 32'h302);
    chk("rel_rd", ex_rd, 5'd13);

    // randomized traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rand_inputs();
      tick();
    end

    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
